// File: rtl/fp_req_pkg.sv
// rtl/fp_req_pkg.sv - shared types and constants for the fp_add requester
package fp_req_pkg;

    localparam int FP_MSB  = 31;
    localparam int FP_FMSB = 22;
    localparam int EMSB    = ((FP_MSB - 1) - FP_FMSB) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    function automatic int word_w(input int msb);
        return msb + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with first-word-fall-through head
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count != CNT_FULL) && !rst;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

endmodule

// File: rtl/fp_add_initiator.sv
// rtl/fp_add_initiator.sv - queues operand pairs and drives the fp_add two-phase req/ack handshake
module fp_add_initiator
    import fp_req_pkg::*;
#(
    parameter int MSB     = 31,
    parameter int FMSB    = 22,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [MSB:0] in_a,
    input  logic [MSB:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [MSB:0] out_data,
    output logic         out_timeout,
    output logic         busy,
    output logic         req,
    input  logic         ack,
    input  logic [MSB:0] tx_data,
    output logic [MSB:0] op_a,
    output logic [MSB:0] op_b,
    output logic         enable
);
    localparam int W  = word_w(MSB);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (FMSB < 1 || FMSB >= MSB - 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("fp_add_initiator: unsupported parameter set");
    end

    state_t          r_state;
    state_t          w_state_nx;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_out_data;
    logic            r_req;
    logic            r_enable;
    logic            r_out_valid;
    logic            r_out_timeout;
    logic [CW-1:0]   r_cnt;
    logic            w_fifo_valid;
    logic [2*W-1:0]  w_fifo_data;
    logic            w_pop;
    logic            w_done;
    logic            w_expire;

    sync_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_a, in_b}),
        .out_valid (w_fifo_valid),
        .out_ready (w_pop),
        .out_data  (w_fifo_data)
    );

    // A launch needs an idle responder and an empty output slot.
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_done     = 1'b0;
        w_expire   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fifo_valid && ack && !r_out_valid) begin
                    w_pop      = 1'b1;
                    w_state_nx = LOAD;
                end
            end
            LOAD: w_state_nx = WAIT_LO;
            WAIT_LO: begin
                if (r_cnt == CNT_MAX) begin
                    w_expire   = 1'b1;
                    w_state_nx = IDLE;
                end else if (!ack) begin
                    w_state_nx = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (ack) begin
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_expire   = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_req         <= 1'b0;
            r_enable      <= 1'b0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_enable <= 1'b1;
            if (w_pop) {r_op_a, r_op_b} <= w_fifo_data;
            if (r_state == LOAD) begin
                r_req <= ~r_req;
                r_cnt <= '0;
            end else if ((r_state == WAIT_LO || r_state == WAIT_HI) && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_done) begin
                r_out_data    <= tx_data;
                r_out_valid   <= 1'b1;
                r_out_timeout <= 1'b0;
            end else if (w_expire) begin
                r_out_data    <= '0;
                r_out_valid   <= 1'b1;
                r_out_timeout <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign req         = r_req;
    assign enable      = r_enable;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_timeout = r_out_timeout;
    assign busy        = (r_state != IDLE) || w_fifo_valid;

endmodule

// File: tb/tb_fp_add_initiator.sv
// tb/tb_fp_add_initiator.sv - directed and random checks of fp_add_initiator against an fp_add responder model
module tb_fp_add_initiator;
    localparam int MSB     = 31;
    localparam int FMSB    = 22;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_timeout;
    logic        busy, req, ack, enable;
    logic [31:0] in_a, in_b, out_data, tx_data, op_a, op_b;

    always #5 clk = ~clk;

    fp_add_initiator #(.MSB(MSB), .FMSB(FMSB), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_timeout(out_timeout), .busy(busy), .req(req),
        .ack(ack), .tx_data(tx_data), .op_a(op_a), .op_b(op_b), .enable(enable)
    );

    int total = 0;
    int bad   = 0;
    int toggles = 0;
    logic mon_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        e = {3'b000, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        int         e;
        logic [24:0] m;
        logic       up;
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e  = int'(d[62:52]) - 896;
        up = d[28] && ((|d[27:0]) || d[29]);
        m  = {2'b01, d[51:29]} + {24'd0, up};
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add_ref(input logic [31:0] a, input logic [31:0] b);
        return d2s($realtobits($bitstoreal(s2d(a)) + $bitstoreal(s2d(b))));
    endfunction

    // fp_add responder: ack idles high, drops after a req toggle, rises with the sum.
    logic        m_last, m_busy, m_hang, m_jit;
    int          m_lat, m_cnt;
    logic [31:0] m_a, m_b, m_res;

    always @(posedge clk) begin
        if (rst) begin
            ack     <= 1'b1;
            tx_data <= '0;
            m_last  <= 1'b0;
            m_busy  <= 1'b0;
            m_cnt   <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                chk("op_a_stable", op_a, m_a);
                chk("op_b_stable", op_b, m_b);
                ack     <= 1'b1;
                tx_data <= m_res;
                m_busy  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (req != m_last) begin
            m_last <= req;
            if (!m_hang) begin
                ack    <= 1'b0;
                m_busy <= 1'b1;
                m_a    <= op_a;
                m_b    <= op_b;
                m_res  <= fp_add_ref(op_a, op_b);
                m_cnt  <= m_lat + (m_jit ? int'($urandom_range(0, 3)) : 0);
            end
        end
    end

    always @(negedge clk) begin
        if (req !== mon_prev) toggles = toggles + 1;
        mon_prev = req;
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("push_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_res(output logic [31:0] d, output logic t);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pop_wait", 32'(out_valid), 32'd1);
        d = out_data;
        t = out_timeout;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] d, ra, rb;
    logic        t, rp;
    int          t0, n, pushed, got;
    logic [31:0] q[$];

    initial begin
        #400000;
        $display("FAIL watchdog actual=%0t required=finish", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1] = '{32'h40400000, 32'h3F800000, 32'h40800000};
        vecs[2] = '{32'hBF800000, 32'h40000000, 32'h3F800000};
        vecs[3] = '{32'h40000000, 32'hC0000000, 32'h00000000};
        vecs[4] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000};
        vecs[5] = '{32'h41200000, 32'h3F800000, 32'h41300000};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        m_hang = 1'b0; m_jit = 1'b0; m_lat = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_timeout", 32'(out_timeout), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_enable", 32'(enable), 1);
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // single operations, one at a time
        for (int i = 0; i < 6; i++) begin
            t0 = toggles;
            push(vecs[i].a, vecs[i].b);
            if (i == 0) begin
                @(posedge clk); #1;
                chk("lat_pop_req", 32'(req), 0);
                chk("lat_pop_op_a", op_a, vecs[0].a);
                chk("lat_pop_op_b", op_b, vecs[0].b);
                @(posedge clk); #1;
                chk("lat_toggle_req", 32'(req), 1);
            end
            pop_res(d, t);
            chk("vec_data", d, vecs[i].exp);
            chk("vec_timeout", 32'(t), 0);
            chk("vec_toggles", toggles - t0, 1);
        end

        // burst into a full FIFO
        out_ready = 1'b0;
        t0 = toggles;
        pushed = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(vecs[i].a, vecs[i].b);
                    pushed++;
                end
            end
            begin
                int nn;
                nn = 0;
                @(negedge clk);
                while (in_ready && nn < 100) begin
                    @(negedge clk);
                    nn++;
                end
                chk("burst_full", 32'(in_ready), 0);
                chk("burst_pushed", pushed, 5);
                repeat (5) @(negedge clk);
                chk("burst_still_full", 32'(in_ready), 0);
                chk("burst_out_valid", 32'(out_valid), 1);
                @(posedge clk); #1;
                for (int i = 0; i < 6; i++) begin
                    pop_res(d, t);
                    chk("burst_data", d, vecs[i].exp);
                end
            end
        join
        chk("burst_toggles", toggles - t0, 6);

        // backpressure on the result
        t0 = toggles;
        push(vecs[0].a, vecs[0].b);
        push(vecs[1].a, vecs[1].b);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid", 32'(out_valid), 1);
        repeat (20) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", out_data, vecs[0].exp);
        end
        chk("bp_toggles_held", toggles - t0, 1);
        pop_res(d, t);
        chk("bp_data0", d, vecs[0].exp);
        pop_res(d, t);
        chk("bp_data1", d, vecs[1].exp);
        chk("bp_toggles", toggles - t0, 2);

        // responder never drops ack
        m_hang = 1'b1;
        rp = req;
        push(vecs[0].a, vecs[0].b);
        n = 0;
        while (req == rp && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (!out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_wait_cycles", n, TIMEOUT + 1);
        pop_res(d, t);
        chk("to_data", d, 0);
        chk("to_flag", 32'(t), 1);
        m_hang = 1'b0;
        push(vecs[1].a, vecs[1].b);
        pop_res(d, t);
        chk("to_next_data", d, vecs[1].exp);
        chk("to_next_flag", 32'(t), 0);

        // reset while waiting for completion
        m_lat = 30;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(vecs[i].a, vecs[i].b);
        n = 0;
        while (ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("mid_req", 32'(req), 1);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_enable", 32'(enable), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rel_busy", 32'(busy), 0);
        chk("mid_rel_in_ready", 32'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rel_no_result", 32'(out_valid), 0);
        chk("mid_rel_idle", 32'(busy), 0);
        out_ready = 1'b0;

        // random operands with random downstream readiness
        m_lat = 1;
        m_jit = 1'b1;
        t0 = toggles;
        got = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = {1'($urandom_range(0, 1)), 8'($urandom_range(107, 157)), 23'($urandom)};
                    rb = {1'($urandom_range(0, 1)), 8'($urandom_range(107, 157)), 23'($urandom)};
                    q.push_back(fp_add_ref(ra, rb));
                    push(ra, rb);
                end
            end
            begin
                int nc;
                nc = 0;
                while (got < 300 && nc < 20000) begin
                    @(negedge clk);
                    nc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (q.size() > 0) chk("rand_data", out_data, q.pop_front());
                        else chk("rand_extra", 32'(out_valid), 0);
                        chk("rand_timeout", 32'(out_timeout), 0);
                        got++;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        chk("rand_count", got, 300);
        chk("rand_toggles", toggles - t0, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
